// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and defaults for the icache/dcache memory request arbiter.
//   arb_op_t    : downstream operation encoding (matches the axi_req port)
//   arb_state_t : arbiter FSM states
//   arb_grant_t : one-hot owner encoding (matches the grant port)
package mem_req_arbiter_pkg;

    localparam int unsigned ARB_BLOCK_W = 128;  // cache line, 4 words
    localparam int unsigned ARB_ADDR_W  = 32;
    localparam int unsigned ARB_WORD_W  = 32;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10
    } arb_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUSY_I = 2'b01,
        ST_BUSY_D = 2'b10,
        ST_LOCK_D = 2'b11
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_I    = 2'b01,
        GNT_D    = 2'b10
    } arb_grant_t;

endpackage

// File: rtl/mem_req_arbiter_rr_picker2.sv
// Two-way round-robin picker.
//   req_icache_i / req_dcache_i : qualified requests this cycle
//   last_i                      : requester granted most recently (GNT_I/GNT_D)
//   gnt_o                       : one-hot grant (GNT_NONE when nobody requests)
module rr_picker2
    import mem_req_arbiter_pkg::*;
(
    input  logic       req_icache_i,
    input  logic       req_dcache_i,
    input  arb_grant_t last_i,
    output arb_grant_t gnt_o
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        gnt_o = GNT_NONE;
        if (req_icache_i && req_dcache_i) begin
            // On a tie the side that did not win last time goes first.
            gnt_o = (last_i == GNT_D) ? GNT_I : GNT_D;
        end else if (req_icache_i) begin
            gnt_o = GNT_I;
        end else if (req_dcache_i) begin
            gnt_o = GNT_D;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbiter sharing one downstream memory port between an icache and a dcache.
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_req/i_addr/...    : icache read request; i_ack accept pulse, i_done completion pulse
//   d_req/d_we/...      : dcache read/write request; d_lock keeps the port for the next dcache request
//   axi_*               : downstream request (driven only while busy) and completion/data return
//   grant               : registered current owner, for debug
// A request is acked combinationally in IDLE (or LOCK_D for the dcache), its fields are
// latched, and the downstream request is held from those latches until axi_task_finish.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned BLOCK_W = ARB_BLOCK_W,
    parameter int unsigned ADDR_W  = ARB_ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    // icache
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic               i_cached,
    output logic               i_ack,
    output logic               i_done,
    output logic [BLOCK_W-1:0] i_rblock,
    output logic [31:0]        i_rword,
    // dcache
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic               d_cached,
    input  logic [BLOCK_W-1:0] d_wblock,
    input  logic [31:0]        d_wword,
    input  logic [3:0]         d_wstrb,
    input  logic               d_lock,
    output logic               d_ack,
    output logic               d_done,
    output logic [BLOCK_W-1:0] d_rblock,
    output logic [31:0]        d_rword,
    // downstream
    output logic [1:0]         axi_req,
    output logic [ADDR_W-1:0]  axi_ad,
    output logic               axi_cached,
    output logic [BLOCK_W-1:0] axi_wblock,
    output logic [31:0]        axi_wword,
    output logic [3:0]         axi_wword_en,
    input  logic               axi_task_finish,
    input  logic [BLOCK_W-1:0] axi_rblock,
    input  logic [31:0]        axi_rword,
    // debug
    output logic [1:0]         grant
);

    arb_state_t state_q, state_d;
    arb_grant_t rr_last_q, rr_last_d;
    arb_grant_t grant_q, grant_d;
    arb_grant_t pick;

    // Latched request fields
    arb_op_t            op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               cached_q;
    logic               lock_q;
    logic [BLOCK_W-1:0] wblock_q;
    logic [31:0]        wword_q;
    logic [3:0]         wstrb_q;

    // Returned data, held until the same requester's next completion
    logic [BLOCK_W-1:0] i_rblock_q, d_rblock_q;
    logic [31:0]        i_rword_q, d_rword_q;
    logic               i_done_q, d_done_q;

    logic busy, is_write, finish_i, finish_d;

    assign busy     = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
    assign is_write = busy && (op_q == OP_WRITE);
    assign finish_i = (state_q == ST_BUSY_I) && axi_task_finish;
    assign finish_d = (state_q == ST_BUSY_D) && axi_task_finish;

    // The icache may only be accepted from IDLE; LOCK_D reserves the port for the dcache.
    rr_picker2 u_picker (
        .req_icache_i (i_req && (state_q == ST_IDLE)),
        .req_dcache_i (d_req && ((state_q == ST_IDLE) || (state_q == ST_LOCK_D))),
        .last_i       (rr_last_q),
        .gnt_o        (pick)
    );

    assign i_ack = (pick == GNT_I);
    assign d_ack = (pick == GNT_D);

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        if (pick != GNT_NONE) begin
            rr_last_d = pick;
        end
        unique case (state_q)
            ST_IDLE, ST_LOCK_D: begin
                if (pick == GNT_I)      state_d = ST_BUSY_I;
                else if (pick == GNT_D) state_d = ST_BUSY_D;
            end
            ST_BUSY_I: if (axi_task_finish) state_d = ST_IDLE;
            ST_BUSY_D: if (axi_task_finish) state_d = lock_q ? ST_LOCK_D : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_BUSY_I:            grant_d = GNT_I;
            ST_BUSY_D, ST_LOCK_D: grant_d = GNT_D;
            default:              grant_d = GNT_NONE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_last_q <= GNT_I;   // dcache wins the first tie
            grant_q   <= GNT_NONE;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            grant_q   <= grant_d;
        end
    end

    // NOTE: the wide data registers are reset too, so no stale line is visible after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_NONE;
            addr_q   <= '0;
            cached_q <= 1'b0;
            lock_q   <= 1'b0;
            wblock_q <= '0;
            wword_q  <= '0;
            wstrb_q  <= '0;
        end else if (pick == GNT_I) begin
            op_q     <= OP_READ;
            addr_q   <= i_addr;
            cached_q <= i_cached;
            lock_q   <= 1'b0;
            wblock_q <= '0;
            wword_q  <= '0;
            wstrb_q  <= '0;
        end else if (pick == GNT_D) begin
            op_q     <= d_we ? OP_WRITE : OP_READ;
            addr_q   <= d_addr;
            cached_q <= d_cached;
            lock_q   <= d_lock;
            wblock_q <= d_wblock;
            wword_q  <= d_wword;
            wstrb_q  <= d_wstrb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            i_rblock_q <= '0;
            i_rword_q  <= '0;
            d_rblock_q <= '0;
            d_rword_q  <= '0;
        end else begin
            i_done_q <= finish_i;
            d_done_q <= finish_d;
            if (finish_i) begin
                i_rblock_q <= axi_rblock;
                i_rword_q  <= axi_rword;
            end
            if (finish_d) begin
                d_rblock_q <= axi_rblock;
                d_rword_q  <= axi_rword;
            end
        end
    end

    assign i_done   = i_done_q;
    assign d_done   = d_done_q;
    assign i_rblock = i_rblock_q;
    assign i_rword  = i_rword_q;
    assign d_rblock = d_rblock_q;
    assign d_rword  = d_rword_q;

    // Downstream is quiet outside BUSY_x; write payload is forced to zero on reads.
    assign axi_req      = busy ? op_q : OP_NONE;
    assign axi_ad       = busy ? addr_q : '0;
    assign axi_cached   = busy ? cached_q : 1'b0;
    assign axi_wblock   = is_write ? wblock_q : '0;
    assign axi_wword    = is_write ? wword_q : '0;
    assign axi_wword_en = is_write ? wstrb_q : '0;

    assign grant = grant_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: a per-cycle vector table for handshake,
// round-robin and lock behaviour, then directed sequences for data paths and reset.
module tb_mem_req_arbiter;

    localparam int BW = 128;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, i_cached, i_ack, i_done;
    logic [AW-1:0] i_addr;
    logic [BW-1:0] i_rblock;
    logic [31:0]   i_rword;
    logic          d_req, d_we, d_cached, d_lock, d_ack, d_done;
    logic [AW-1:0] d_addr;
    logic [BW-1:0] d_wblock, d_rblock;
    logic [31:0]   d_wword, d_rword;
    logic [3:0]    d_wstrb;
    logic [1:0]    axi_req, grant;
    logic [AW-1:0] axi_ad;
    logic          axi_cached, axi_task_finish;
    logic [BW-1:0] axi_wblock, axi_rblock;
    logic [31:0]   axi_wword, axi_rword;
    logic [3:0]    axi_wword_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(.BLOCK_W(BW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_cached(i_cached),
        .i_ack(i_ack), .i_done(i_done), .i_rblock(i_rblock), .i_rword(i_rword),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_cached(d_cached),
        .d_wblock(d_wblock), .d_wword(d_wword), .d_wstrb(d_wstrb), .d_lock(d_lock),
        .d_ack(d_ack), .d_done(d_done), .d_rblock(d_rblock), .d_rword(d_rword),
        .axi_req(axi_req), .axi_ad(axi_ad), .axi_cached(axi_cached),
        .axi_wblock(axi_wblock), .axi_wword(axi_wword), .axi_wword_en(axi_wword_en),
        .axi_task_finish(axi_task_finish), .axi_rblock(axi_rblock), .axi_rword(axi_rword),
        .grant(grant)
    );

    typedef struct {
        logic       ireq, dreq, dwe, dlock, fin;
        logic       iack, dack;
        logic [1:0] areq;
        logic       idone, ddone;
        logic [1:0] gnt;
        logic [3:0] wen;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ireq, dreq, dwe, dlock, fin,
                                input logic iack, dack, input logic [1:0] areq,
                                input logic idone, ddone, input logic [1:0] gnt,
                                input logic [3:0] wen);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.dwe = dwe; v.dlock = dlock; v.fin = fin;
        v.iack = iack; v.dack = dack; v.areq = areq;
        v.idone = idone; v.ddone = ddone; v.gnt = gnt; v.wen = wen;
        return v;
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_req = 0; i_addr = '0; i_cached = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_cached = 0; d_lock = 0;
        d_wblock = '0; d_wword = '0; d_wstrb = '0;
        axi_task_finish = 0; axi_rblock = '0; axi_rword = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst_n = 0;
        sample();
        check("rst grant", grant, 2'b00);
        check("rst axi_req", axi_req, 2'b00);
        check("rst acks", {i_ack, d_ack}, 2'b00);
        check("rst dones", {i_done, d_done}, 2'b00);
        check("rst i_rblock", i_rblock, '0);
        check("rst d_rword", d_rword, '0);
        tick();
        rst_n = 1;

        // Per-cycle vectors: ireq dreq dwe dlock fin | iack dack areq idone ddone grant wen
        // Ties after reset: dcache first, then alternate.
        vecs.push_back(mk(1,1,0,0,0, 0,1,2'b00,0,0,2'b00,4'h0));
        vecs.push_back(mk(1,0,0,0,0, 0,0,2'b01,0,0,2'b10,4'h0));
        vecs.push_back(mk(1,0,0,0,1, 0,0,2'b01,0,0,2'b10,4'h0));
        vecs.push_back(mk(1,1,0,0,0, 1,0,2'b00,0,1,2'b00,4'h0));
        vecs.push_back(mk(0,1,0,0,1, 0,0,2'b01,0,0,2'b01,4'h0));
        vecs.push_back(mk(1,1,0,0,0, 0,1,2'b00,1,0,2'b00,4'h0));
        vecs.push_back(mk(1,0,0,0,1, 0,0,2'b01,0,0,2'b10,4'h0));
        vecs.push_back(mk(1,0,0,0,0, 1,0,2'b00,0,1,2'b00,4'h0));
        vecs.push_back(mk(0,0,0,0,1, 0,0,2'b01,0,0,2'b01,4'h0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,2'b00,1,0,2'b00,4'h0));
        // icache read, finish 5 cycles after ack
        vecs.push_back(mk(1,0,0,0,0, 1,0,2'b00,0,0,2'b00,4'h0));
        for (int n = 0; n < 4; n++)
            vecs.push_back(mk(0,0,0,0,0, 0,0,2'b01,0,0,2'b01,4'h0));
        vecs.push_back(mk(0,0,0,0,1, 0,0,2'b01,0,0,2'b01,4'h0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,2'b00,1,0,2'b00,4'h0));
        // finish pulse while idle is ignored
        vecs.push_back(mk(0,0,0,0,1, 0,0,2'b00,0,0,2'b00,4'h0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,2'b00,0,0,2'b00,4'h0));
        // locked writeback, icache held off in LOCK_D, then dcache read, then icache
        vecs.push_back(mk(0,1,1,1,0, 0,1,2'b00,0,0,2'b00,4'h0));
        vecs.push_back(mk(1,0,0,0,0, 0,0,2'b10,0,0,2'b10,4'hF));
        vecs.push_back(mk(1,0,0,0,1, 0,0,2'b10,0,0,2'b10,4'hF));
        vecs.push_back(mk(1,0,0,0,0, 0,0,2'b00,0,1,2'b10,4'h0));
        vecs.push_back(mk(1,0,0,0,0, 0,0,2'b00,0,0,2'b10,4'h0));
        vecs.push_back(mk(1,1,0,0,0, 0,1,2'b00,0,0,2'b10,4'h0));
        vecs.push_back(mk(1,0,0,0,1, 0,0,2'b01,0,0,2'b10,4'h0));
        vecs.push_back(mk(1,0,0,0,0, 1,0,2'b00,0,1,2'b00,4'h0));
        vecs.push_back(mk(0,0,0,0,1, 0,0,2'b01,0,0,2'b01,4'h0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,2'b00,1,0,2'b00,4'h0));

        i_addr = 32'h1C00_0000; i_cached = 1;
        d_addr = 32'h8000_0100; d_cached = 1; d_wstrb = 4'hF;
        foreach (vecs[r]) begin
            i_req = vecs[r].ireq; d_req = vecs[r].dreq; d_we = vecs[r].dwe;
            d_lock = vecs[r].dlock; axi_task_finish = vecs[r].fin;
            sample();
            check($sformatf("row%0d acks", r), {i_ack, d_ack}, {vecs[r].iack, vecs[r].dack});
            check($sformatf("row%0d axi_req", r), axi_req, vecs[r].areq);
            check($sformatf("row%0d dones", r), {i_done, d_done}, {vecs[r].idone, vecs[r].ddone});
            check($sformatf("row%0d grant", r), grant, vecs[r].gnt);
            check($sformatf("row%0d wword_en", r), axi_wword_en, vecs[r].wen);
            tick();
        end
        clear_inputs();

        // icache read: inputs change after ack, data returned on finish at cycle 5
        i_req = 1; i_addr = 32'h1C00_0000; i_cached = 1;
        sample();
        check("i ack", i_ack, 1'b1);
        tick();
        i_req = 0; i_addr = 32'hDEAD_BEEF; i_cached = 0;
        sample();
        check("i axi_ad held", axi_ad, 32'h1C00_0000);
        check("i axi_cached held", axi_cached, 1'b1);
        check("i axi_wblock zero", axi_wblock, '0);
        repeat (4) tick();
        axi_rblock = {32'h0123_4567, 32'h89AB_CDEF, 32'h0F1E_2D3C, 32'h4B5A_6978};
        axi_rword = 32'h5555_AAAA; axi_task_finish = 1;
        tick();
        axi_task_finish = 0; axi_rblock = '0; axi_rword = '0;
        sample();
        check("i done", i_done, 1'b1);
        check("i rblock", i_rblock, {32'h0123_4567, 32'h89AB_CDEF, 32'h0F1E_2D3C, 32'h4B5A_6978});
        check("i rword", i_rword, 32'h5555_AAAA);
        tick();
        sample();
        check("i done one cycle", i_done, 1'b0);
        check("i rblock held", i_rblock, {32'h0123_4567, 32'h89AB_CDEF, 32'h0F1E_2D3C, 32'h4B5A_6978});

        // Uncached dcache read with junk write payload present on inputs
        tick();
        d_req = 1; d_we = 0; d_addr = 32'hBFAF_8000; d_cached = 0;
        d_wblock = '1; d_wword = 32'hFFFF_FFFF; d_wstrb = 4'hF;
        sample();
        check("dr ack", d_ack, 1'b1);
        tick();
        d_req = 0;
        axi_rword = 32'h1234_5678; axi_rblock = {4{32'h7777_0000}}; axi_task_finish = 1;
        sample();
        check("dr axi_req", axi_req, 2'b01);
        check("dr axi_ad", axi_ad, 32'hBFAF_8000);
        check("dr axi_cached", axi_cached, 1'b0);
        check("dr wblock zero", axi_wblock, '0);
        check("dr wword zero", axi_wword, 32'h0);
        tick();
        axi_task_finish = 0; axi_rword = '0; axi_rblock = '0;
        sample();
        check("dr done", d_done, 1'b1);
        check("dr rword", d_rword, 32'h1234_5678);
        check("dr rblock", d_rblock, {4{32'h7777_0000}});
        check("dr i_rword untouched", i_rword, 32'h5555_AAAA);

        // Unlocked dcache write: payload latched at ack, inputs changed afterwards
        tick();
        d_req = 1; d_we = 1; d_lock = 0; d_cached = 1; d_addr = 32'h0000_1040;
        d_wblock = {32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3, 32'hD4D4_D4D4};
        d_wword = 32'hCAFE_F00D; d_wstrb = 4'h5;
        sample();
        check("dw ack", d_ack, 1'b1);
        tick();
        d_req = 0; d_wblock = '0; d_wword = '0; d_wstrb = '0; d_addr = '0;
        sample();
        check("dw axi_req", axi_req, 2'b10);
        check("dw axi_ad", axi_ad, 32'h0000_1040);
        check("dw wblock", axi_wblock, {32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3, 32'hD4D4_D4D4});
        check("dw wword", axi_wword, 32'hCAFE_F00D);
        check("dw wword_en", axi_wword_en, 4'h5);
        tick();
        axi_task_finish = 1;
        tick();
        axi_task_finish = 0;
        sample();
        check("dw done", d_done, 1'b1);
        check("dw back to idle", {axi_req, grant}, 4'b0000);

        // Reset during BUSY_D, finish arrives two cycles after reset asserted
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h9000_0000;
        sample();
        check("rb ack", d_ack, 1'b1);
        tick();
        d_req = 0;
        sample();
        check("rb busy", {axi_req, grant}, 4'b0110);
        tick();
        rst_n = 0;
        sample();
        check("rb in reset", {axi_req, grant, d_done}, 5'b00000);
        tick();
        rst_n = 1;
        tick();
        axi_task_finish = 1; axi_rword = 32'h0BAD_0BAD;
        sample();
        check("rb finish ignored", {axi_req, grant}, 4'b0000);
        tick();
        axi_task_finish = 0; axi_rword = '0;
        sample();
        check("rb no done", {i_done, d_done}, 2'b00);
        check("rb d_rword cleared", d_rword, 32'h0);
        tick();
        sample();
        check("rb still quiet", {d_done, axi_req, grant}, 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
